bus_test_sequencer: RTL and testbench

- Parametrised stimulus sequencer for the shared-bus testbench. Drives enable, read-enable, address and data for NUM_MASTERS bus masters from a command latched at start.
- Supports simultaneous or staggered issue (per-master gap), a bus-idle wait with timeout, and a done pulse.
- Sits between the top-level test control and the master ports. Generalises the fixed two-master scenario controller.

---
 rtl/bus_test_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_bus_test_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_test_sequencer.sv
// bus_test_sequencer: latches a command and drives enable/read/addr/data to NUM_MASTERS bus masters.
// Optional macro BUS_SEQ_REPEAT_EN adds cmd_repeat for multi-pass reissue of the same command.

module bus_seq_lane #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issue,
  input  logic          clear,
  input  logic          rd,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          enable,
  output logic          read_en,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);
  // Fields are loaded when the lane issues and then held until the sequencer returns to idle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      enable  <= 1'b0;
      read_en <= 1'b0;
      addr    <= '0;
      data    <= '0;
    end else begin
      enable <= issue;
      if (issue) begin
        read_en <= rd;
        addr    <= cmd_addr;
        data    <= cmd_data;
      end
    end
  end
endmodule

module bus_test_sequencer #(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 14,
  parameter int HOLD_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_MASTERS-1:0]            cmd_mask,
  input  logic [NUM_MASTERS-1:0]            cmd_read,
  input  logic                              cmd_stagger,
  input  logic [7:0]                        cmd_gap,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] cmd_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] cmd_data,
`ifdef BUS_SEQ_REPEAT_EN
  input  logic [3:0]                        cmd_repeat,
`endif
  input  logic [NUM_MASTERS-1:0]            m_request,
  output logic [NUM_MASTERS-1:0]            m_enable,
  output logic [NUM_MASTERS-1:0]            m_read_en,
  output logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_in,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [2:0]                        state_out
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_CYCLES);
  localparam logic [WW-1:0] WAIT_LIM = WW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_ISSUE = 3'd1, S_GAP = 3'd2, S_WAIT = 3'd3, S_DONE = 3'd4
  } state_t;

  typedef struct packed {
    logic [NUM_MASTERS-1:0]            mask;
    logic [NUM_MASTERS-1:0]            read;
    logic                              stagger;
    logic [7:0]                        gap;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] data;
  } cmd_t;

  state_t                 state, state_nxt;
  cmd_t                   cmd_q, cmd_cur;
  logic [HW-1:0]          hold_cnt;
  logic [7:0]             gap_cnt;
  logic [WW-1:0]          wait_cnt;
  logic [PW-1:0]          ptr, ptr_nxt, first_idx, next_idx;
  logic                   has_next, accept, issue_start, more_passes;
  logic [NUM_MASTERS-1:0] en_nxt;

  assign accept    = (state == S_IDLE) && start;
  assign state_out = state;

  // In IDLE the live command inputs are used so the first issue lands on the cycle after start.
  always_comb begin
    cmd_cur = cmd_q;
    if (state == S_IDLE) begin
      cmd_cur.mask    = cmd_mask;
      cmd_cur.read    = cmd_read;
      cmd_cur.stagger = cmd_stagger;
      cmd_cur.gap     = cmd_gap;
      cmd_cur.addr    = cmd_addr;
      cmd_cur.data    = cmd_data;
    end
  end

  always_comb begin
    first_idx = '0;
    next_idx  = ptr;
    has_next  = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (cmd_cur.mask[i]) first_idx = PW'(i);
      if (cmd_q.mask[i] && i > int'(ptr)) begin
        next_idx = PW'(i);
        has_next = 1'b1;
      end
    end
  end

`ifdef BUS_SEQ_REPEAT_EN
  logic [3:0] rep_q, pass_cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_q    <= '0;
      pass_cnt <= '0;
    end else if (accept) begin
      rep_q    <= cmd_repeat;
      pass_cnt <= '0;
    end else if (state == S_WAIT && state_nxt == S_ISSUE) begin
      pass_cnt <= pass_cnt + 4'd1;
    end
  end
  assign more_passes = (pass_cnt != rep_q);
`else
  assign more_passes = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (cmd_mask == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (hold_cnt == HOLD_LIM) begin
                 if (cmd_q.stagger && has_next) state_nxt = (cmd_q.gap == 8'd0) ? S_ISSUE : S_GAP;
                 else                           state_nxt = S_WAIT;
               end
      S_GAP:   if (gap_cnt == cmd_q.gap) state_nxt = S_ISSUE;
      S_WAIT:  if (m_request == '0)         state_nxt = more_passes ? S_ISSUE : S_DONE;
               else if (wait_cnt == WAIT_LIM) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Back-to-back staggered issues (gap 0) restart the hold count without leaving ISSUE.
  assign issue_start = (state_nxt == S_ISSUE) && (state != S_ISSUE || hold_cnt == HOLD_LIM);

  always_comb begin
    ptr_nxt = ptr;
    if (issue_start) ptr_nxt = (state == S_ISSUE || state == S_GAP) ? next_idx : first_idx;
    en_nxt = '0;
    if (state_nxt == S_ISSUE)
      for (int i = 0; i < NUM_MASTERS; i++)
        en_nxt[i] = cmd_cur.stagger ? (int'(ptr_nxt) == i) : cmd_cur.mask[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      wait_cnt <= '0;
      ptr      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      ptr  <= ptr_nxt;
      busy <= (state_nxt != S_IDLE);
      done <= (state_nxt == S_DONE);
      if (accept) begin
        cmd_q   <= cmd_cur;
        timeout <= 1'b0;
      end else if (state == S_WAIT && m_request != '0 && wait_cnt == WAIT_LIM) begin
        timeout <= 1'b1;
      end
      if (issue_start)                                  hold_cnt <= HW'(1);
      else if (state == S_ISSUE && hold_cnt != HOLD_LIM) hold_cnt <= hold_cnt + 1'b1;
      if (state_nxt == S_GAP && state != S_GAP)         gap_cnt <= 8'd1;
      else if (state == S_GAP && gap_cnt != 8'hFF)      gap_cnt <= gap_cnt + 8'd1;
      if (state_nxt == S_WAIT && state != S_WAIT)       wait_cnt <= WW'(1);
      else if (state == S_WAIT && wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_lane
    bus_seq_lane #(.AW(ADDR_WIDTH), .DW(DATA_WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .issue    (en_nxt[g]),
      .clear    (state_nxt == S_IDLE),
      .rd       (cmd_cur.read[g]),
      .cmd_addr (cmd_cur.addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .cmd_data (cmd_cur.data[g*DATA_WIDTH +: DATA_WIDTH]),
      .enable   (m_enable[g]),
      .read_en  (m_read_en[g]),
      .addr     (addr_in[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .data     (data_in[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_bus_test_sequencer.sv
// Directed bench for bus_test_sequencer: cycle table plus stagger, timeout and reset sequences.
module tb_bus_test_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, cmd_stagger;
  logic [1:0]  cmd_mask, cmd_read, m_request;
  logic [7:0]  cmd_gap;
  logic [27:0] cmd_addr;
  logic [15:0] cmd_data;
  logic [1:0]  m_enable, m_read_en;
  logic [27:0] addr_in;
  logic [15:0] data_in;
  logic        busy, done, timeout;
  logic [2:0]  state_out;

  always #5 clk = ~clk;

  // Short timeout so the abort path is reachable in a few cycles.
  bus_test_sequencer #(
    .NUM_MASTERS(2), .DATA_WIDTH(8), .ADDR_WIDTH(14), .HOLD_CYCLES(3), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cmd_mask(cmd_mask), .cmd_read(cmd_read),
    .cmd_stagger(cmd_stagger), .cmd_gap(cmd_gap), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en), .addr_in(addr_in),
    .data_in(data_in), .busy(busy), .done(done), .timeout(timeout), .state_out(state_out)
  );

  typedef struct packed {
    logic [1:0] en, rd; logic [27:0] addr; logic [15:0] data;
    logic busy, done, tmo; logic [2:0] st;
  } outs_t;

  typedef struct {
    logic rst, start; logic [1:0] mask, read; logic stag; logic [7:0] gap;
    logic [27:0] addr; logic [15:0] data; logic [1:0] req; outs_t exp;
  } vec_t;

  int tests = 0, fails = 0;
  vec_t vecs[16];

  function automatic outs_t o(logic [1:0] en, logic [1:0] rd, logic [27:0] a, logic [15:0] d,
                              logic b, logic dn, logic t, logic [2:0] st);
    outs_t r;
    r = '{en, rd, a, d, b, dn, t, st};
    return r;
  endfunction

  function automatic vec_t v(logic rst, logic st, logic [1:0] m, logic [1:0] rd, logic [27:0] a,
                             logic [15:0] d, logic [1:0] rq, outs_t e);
    vec_t r;
    r.rst = rst; r.start = st; r.mask = m; r.read = rd; r.stag = 1'b0; r.gap = 8'd0;
    r.addr = a; r.data = d; r.req = rq; r.exp = e;
    return r;
  endfunction

  // Expected outputs for a mask=01 non-staggered command: 3 ISSUE, n WAIT, DONE, then IDLE.
  function automatic outs_t se(int c, int n, logic t, logic [1:0] rd, logic [27:0] a, logic [15:0] d);
    if (c <= 3)     return o(2'b01, rd, a, d, 1'b1, 1'b0, 1'b0, 3'd1);
    if (c <= 3 + n) return o(2'b00, rd, a, d, 1'b1, 1'b0, 1'b0, 3'd3);
    if (c == 4 + n) return o(2'b00, rd, a, d, 1'b1, 1'b1, t, 3'd4);
    return o(2'b00, 2'b00, 28'd0, 16'd0, 1'b0, 1'b0, t, 3'd0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input outs_t e);
    outs_t a;
    a = '{m_enable, m_read_en, addr_in, data_in, busy, done, timeout, state_out};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got en=%b rd=%b addr=%h data=%h busy=%b done=%b tmo=%b st=%0d; want en=%b rd=%b addr=%h data=%h busy=%b done=%b tmo=%b st=%0d",
               name, a.en, a.rd, a.addr, a.data, a.busy, a.done, a.tmo, a.st,
               e.en, e.rd, e.addr, e.data, e.busy, e.done, e.tmo, e.st);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [1:0] rd, input logic stg, input logic [7:0] g,
                       input logic [27:0] a, input logic [15:0] d);
    cmd_mask = m; cmd_read = rd; cmd_stagger = stg; cmd_gap = g; cmd_addr = a; cmd_data = d;
  endtask

  localparam logic [27:0] A0 = {14'd0, 14'd1001};
  localparam logic [15:0] D0 = {8'd0, 8'd101};
  localparam logic [27:0] SA = {14'd5097, 14'd5098};
  localparam logic [15:0] SD = {8'h22, 8'h11};
  localparam outs_t Z = '0;

  initial begin
    reset = 1'b1; start = 1'b0; m_request = 2'b00;
    drive(2'b00, 2'b00, 1'b0, 8'd0, 28'd0, 16'd0);

    vecs[0]  = v(1, 0, 2'b00, 2'b00, 0,  0,  2'b00, Z);
    vecs[1]  = v(0, 1, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b01, 2'b00, A0, D0, 1, 0, 0, 3'd1));
    vecs[2]  = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b01, 2'b00, A0, D0, 1, 0, 0, 3'd1));
    vecs[3]  = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b01, 2'b00, A0, D0, 1, 0, 0, 3'd1));
    vecs[4]  = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b00, 2'b00, A0, D0, 1, 0, 0, 3'd3));
    vecs[5]  = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b00, 2'b00, A0, D0, 1, 1, 0, 3'd4));
    vecs[6]  = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, Z);
    vecs[7]  = v(0, 1, 2'b11, 2'b11, SA, SD, 2'b00, o(2'b11, 2'b11, SA, SD, 1, 0, 0, 3'd1));
    vecs[8]  = v(0, 0, 2'b11, 2'b11, SA, SD, 2'b00, o(2'b11, 2'b11, SA, SD, 1, 0, 0, 3'd1));
    vecs[9]  = v(0, 0, 2'b11, 2'b11, SA, SD, 2'b00, o(2'b11, 2'b11, SA, SD, 1, 0, 0, 3'd1));
    vecs[10] = v(0, 0, 2'b11, 2'b11, SA, SD, 2'b01, o(2'b00, 2'b11, SA, SD, 1, 0, 0, 3'd3));
    vecs[11] = v(0, 1, 2'b01, 2'b00, A0, D0, 2'b01, o(2'b00, 2'b11, SA, SD, 1, 0, 0, 3'd3));
    vecs[12] = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, o(2'b00, 2'b11, SA, SD, 1, 1, 0, 3'd4));
    vecs[13] = v(0, 0, 2'b01, 2'b00, A0, D0, 2'b00, Z);
    vecs[14] = v(0, 1, 2'b00, 2'b00, A0, D0, 2'b00, o(2'b00, 2'b00, 0, 0, 1, 1, 0, 3'd4));
    vecs[15] = v(0, 0, 2'b00, 2'b00, A0, D0, 2'b00, Z);

    foreach (vecs[k]) begin
      reset = vecs[k].rst; start = vecs[k].start; m_request = vecs[k].req;
      drive(vecs[k].mask, vecs[k].read, vecs[k].stag, vecs[k].gap, vecs[k].addr, vecs[k].data);
      step();
      check($sformatf("vec%0d", k), vecs[k].exp);
    end
    start = 1'b0;

    // Staggered issue, gap 5: master0 c1..3, gap c4..8, master1 c9..11.
    drive(2'b11, 2'b00, 1'b1, 8'd5, {14'd1001, 14'd777}, {8'd102, 8'd77});
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      outs_t e;
      logic [27:0] a;
      logic [15:0] d;
      step();
      start = 1'b0;
      a = (c < 9) ? {14'd0, 14'd777} : {14'd1001, 14'd777};
      d = (c < 9) ? {8'd0, 8'd77} : {8'd102, 8'd77};
      if (c <= 3)       e = o(2'b01, 2'b00, a, d, 1, 0, 0, 3'd1);
      else if (c <= 8)  e = o(2'b00, 2'b00, a, d, 1, 0, 0, 3'd2);
      else if (c <= 11) e = o(2'b10, 2'b00, a, d, 1, 0, 0, 3'd1);
      else if (c == 12) e = o(2'b00, 2'b00, a, d, 1, 0, 0, 3'd3);
      else if (c == 13) e = o(2'b00, 2'b00, a, d, 1, 1, 0, 3'd4);
      else              e = Z;
      check($sformatf("stagger_c%0d", c), e);
    end

    // Timeout: request stuck at 10 for 4 WAIT cycles.
    drive(2'b01, 2'b01, 1'b0, 8'd0, {14'd0, 14'd42}, {8'd0, 8'd9});
    m_request = 2'b10; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start = 1'b0;
      check($sformatf("timeout_c%0d", c), se(c, 4, 1'b1, 2'b01, {14'd0, 14'd42}, {8'd0, 8'd9}));
    end

    // Next start clears the sticky timeout.
    m_request = 2'b00; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      start = 1'b0;
      check($sformatf("restart_c%0d", c), se(c, 1, 1'b0, 2'b01, {14'd0, 14'd42}, {8'd0, 8'd9}));
    end

    // Request falls in the same cycle the wait counter hits the limit: success.
    m_request = 2'b11; start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start = 1'b0;
      check($sformatf("limit_c%0d", c), se(c, 4, 1'b0, 2'b01, {14'd0, 14'd42}, {8'd0, 8'd9}));
      if (c == 7) m_request = 2'b00;
    end

    // Reset during ISSUE aborts without a done pulse.
    drive(2'b01, 2'b00, 1'b0, 8'd0, A0, D0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("rst_issue", o(2'b01, 2'b00, A0, D0, 1, 0, 0, 3'd1));
    reset = 1'b1;
    step();
    check("rst_abort", Z);
    reset = 1'b0;
    step();
    check("rst_no_done", Z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
